// File: rtl/x86_core.sv
// rtl/x86_core.sv - DownGrade88: minimal real-mode 8086 subset core on a byte-wide bus
// Multi-cycle FSM: one byte per cycle, operands gathered into imm_q before EXEC.
module x86_core (
  input  logic        clock,
  input  logic        reset_n,
  output logic [19:0] address,
  input  logic [7:0]  in,
  output logic [7:0]  out,
  output logic        we
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_IMM    = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEMRD  = 3'd4;
  localparam logic [2:0] S_MEMWR  = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [15:0]      ip_q, ip_d, es_q, es_d, ss_q, ss_d, ds_q, ds_d, cs_q;
  logic [7:0][15:0] regs_q, regs_d;
  logic             cf_q, cf_d, pf_q, pf_d, zf_q, zf_d, sf_q, sf_d, of_q, of_d;
  logic [7:0]       op_q, op_d, out_q, out_d;
  logic [15:0]      imm_q, imm_d;
  logic             cnt_q, cnt_d, we_q, we_d;
  logic [19:0]      addr_q, addr_d;

  logic        w, sa, sb, sr, alu_cf, alu_of, cond, take;
  logic [15:0] a_op, b_op, alu_r, id_r;
  logic [16:0] add_r, sub_r;

  assign address = addr_q;
  assign out     = out_q;
  assign we      = we_q;

  function automatic logic [19:0] phys(input logic [15:0] seg, input logic [15:0] off);
    return {seg, 4'h0} + {4'h0, off};
  endfunction

  function automatic logic [1:0] imm_len(input logic [7:0] op);
    if (op[7:4] == 4'hB) return op[3] ? 2'd2 : 2'd1;
    if (op[7:6] == 2'b00 && op[2:1] == 2'b10 && op[5:4] != 2'b01) return op[0] ? 2'd2 : 2'd1;
    if (op[7:2] == 6'b101000 || op == 8'hE9) return 2'd2;
    if (op == 8'h8E || op == 8'hEB || op[7:4] == 4'h7) return 2'd1;
    return 2'd0;
  endfunction

  // Byte ops run zero-extended so bit 8 of the 17-bit result is the byte carry/borrow.
  always_comb begin
    w      = op_q[0];
    a_op   = w ? regs_q[0] : {8'h00, regs_q[0][7:0]};
    b_op   = w ? imm_q : {8'h00, imm_q[7:0]};
    add_r  = {1'b0, a_op} + {1'b0, b_op};
    sub_r  = {1'b0, a_op} - {1'b0, b_op};
    alu_r  = 16'h0000;
    alu_cf = 1'b0;
    alu_of = 1'b0;
    sa     = w ? a_op[15] : a_op[7];
    sb     = w ? b_op[15] : b_op[7];
    case (op_q[5:3])
      3'b000:  begin alu_r = add_r[15:0]; alu_cf = w ? add_r[16] : add_r[8]; end
      3'b001:  alu_r = a_op | b_op;
      3'b100:  alu_r = a_op & b_op;
      3'b110:  alu_r = a_op ^ b_op;
      default: begin alu_r = sub_r[15:0]; alu_cf = w ? sub_r[16] : sub_r[8]; end
    endcase
    sr = w ? alu_r[15] : alu_r[7];
    if (op_q[5:3] == 3'b000) alu_of = (sa == sb) && (sr != sa);
    else if (op_q[5:3] == 3'b101 || op_q[5:3] == 3'b111) alu_of = (sa != sb) && (sr != sa);
    id_r = op_q[3] ? regs_q[op_q[2:0]] - 16'd1 : regs_q[op_q[2:0]] + 16'd1;
    case (op_q[3:1])
      3'd0:    cond = of_q;
      3'd1:    cond = cf_q;
      3'd2:    cond = zf_q;
      3'd3:    cond = cf_q | zf_q;
      3'd4:    cond = sf_q;
      3'd5:    cond = pf_q;
      3'd6:    cond = sf_q ^ of_q;
      default: cond = zf_q | (sf_q ^ of_q);
    endcase
    take = cond ^ op_q[0];
  end

  always_comb begin
    state_d = state_q; ip_d = ip_q; regs_d = regs_q;
    es_d = es_q; ss_d = ss_q; ds_d = ds_q;
    cf_d = cf_q; pf_d = pf_q; zf_d = zf_q; sf_d = sf_q; of_d = of_q;
    op_d = op_q; imm_d = imm_q; cnt_d = cnt_q;
    addr_d = addr_q; out_d = out_q; we_d = 1'b0;
    case (state_q)
      S_FETCH: begin
        addr_d  = phys(cs_q, ip_q);
        ip_d    = ip_q + 16'd1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d  = in;
        cnt_d = 1'b0;
        imm_d = 16'h0000;
        if (imm_len(in) != 2'd0) begin
          addr_d  = phys(cs_q, ip_q);
          ip_d    = ip_q + 16'd1;
          state_d = S_IMM;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_IMM: begin
        if (!cnt_q) imm_d[7:0] = in;
        else        imm_d[15:8] = in;
        if (!cnt_q && imm_len(op_q) == 2'd2) begin
          addr_d = phys(cs_q, ip_q);
          ip_d   = ip_q + 16'd1;
          cnt_d  = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        cnt_d   = 1'b0;
        casez (op_q)
          8'b1011_0???: begin
            if (op_q[2]) regs_d[{1'b0, op_q[1:0]}][15:8] = imm_q[7:0];
            else         regs_d[{1'b0, op_q[1:0]}][7:0]  = imm_q[7:0];
          end
          8'b1011_1???: regs_d[op_q[2:0]] = imm_q;
          8'b0100_????: begin
            regs_d[op_q[2:0]] = id_r;
            zf_d = (id_r == 16'h0000);
            sf_d = id_r[15];
            pf_d = ~^id_r[7:0];
            of_d = op_q[3] ? (id_r == 16'h7FFF) : (id_r == 16'h8000);
          end
          8'b00??_?10?: begin
            if (op_q[5:4] != 2'b01) begin
              if (op_q[5:3] != 3'b111) begin
                if (w) regs_d[0] = alu_r;
                else   regs_d[0][7:0] = alu_r[7:0];
              end
              zf_d = w ? (alu_r == 16'h0000) : (alu_r[7:0] == 8'h00);
              sf_d = sr;
              pf_d = ~^alu_r[7:0];
              cf_d = alu_cf;
              of_d = alu_of;
            end
          end
          8'b1010_00??: begin
            addr_d = phys(ds_q, imm_q);
            if (op_q[1]) begin
              out_d   = regs_q[0][7:0];
              we_d    = 1'b1;
              cnt_d   = op_q[0];
              state_d = S_MEMWR;
            end else begin
              state_d = S_MEMRD;
            end
          end
          8'h8E: begin
            if (imm_q[7:6] == 2'b11) begin
              case (imm_q[5:3])
                3'd0:    es_d = regs_q[imm_q[2:0]];
                3'd2:    ss_d = regs_q[imm_q[2:0]];
                3'd3:    ds_d = regs_q[imm_q[2:0]];
                default: ;
              endcase
            end
          end
          8'hEB:        ip_d = ip_q + {{8{imm_q[7]}}, imm_q[7:0]};
          8'hE9:        ip_d = ip_q + imm_q;
          8'b0111_????: if (take) ip_d = ip_q + {{8{imm_q[7]}}, imm_q[7:0]};
          8'hF8:        cf_d = 1'b0;
          8'hF9:        cf_d = 1'b1;
          8'hF4:        state_d = S_HALT;
          default:      ;
        endcase
      end
      S_MEMRD: begin
        if (!cnt_q) regs_d[0][7:0] = in;
        else        regs_d[0][15:8] = in;
        if (!cnt_q && op_q[0]) begin
          addr_d = phys(ds_q, imm_q + 16'd1);
          cnt_d  = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMWR: begin
        if (cnt_q) begin
          addr_d = phys(ds_q, imm_q + 16'd1);
          out_d  = regs_q[0][15:8];
          we_d   = 1'b1;
          cnt_d  = 1'b0;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALT:  ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH; ip_q <= '0; regs_q <= '0;
      es_q <= '0; cs_q <= '0; ss_q <= '0; ds_q <= '0;
      cf_q <= 1'b0; pf_q <= 1'b0; zf_q <= 1'b0; sf_q <= 1'b0; of_q <= 1'b0;
      op_q <= '0; imm_q <= '0; cnt_q <= 1'b0;
      addr_q <= '0; out_q <= '0; we_q <= 1'b0;
    end else begin
      state_q <= state_d; ip_q <= ip_d; regs_q <= regs_d;
      es_q <= es_d; cs_q <= cs_q; ss_q <= ss_d; ds_q <= ds_d;
      cf_q <= cf_d; pf_q <= pf_d; zf_q <= zf_d; sf_q <= sf_d; of_q <= of_d;
      op_q <= op_d; imm_q <= imm_d; cnt_q <= cnt_d;
      addr_q <= addr_d; out_q <= out_d; we_q <= we_d;
    end
  end
endmodule

// File: tb/tb_x86_core.sv
// tb/tb_x86_core.sv - directed program tests for x86_core against a 1 MB byte memory
module tb_x86_core;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [19:0] address;
  logic [7:0]  mem_rd, out;
  logic        we;

  logic [7:0]  pmem [0:1048575];
  logic [7:0]  wmem [0:1048575];
  int          wtag [0:1048575];
  int          epoch = 0;
  int          wr_n = 0, cnt3 = 0, cyc = 0;
  logic [19:0] prev_addr = '0;
  logic [19:0] wr_a [0:63];
  int          wr_t [0:63];
  int          n_tests = 0, n_fail = 0;
  int          w0, c0, wn;
  logic [19:0] ha, pa;
  logic [5:0]  i0, i1;
  logic [7:0]  prog [$];

  x86_core dut (
    .clock   (clock),
    .reset_n (reset_n),
    .address (address),
    .in      (mem_rd),
    .out     (out),
    .we      (we)
  );

  always #5 clock = ~clock;

  // Program bytes live in pmem; bytes written in the current test shadow them.
  assign mem_rd = (wtag[address] == epoch) ? wmem[address] : pmem[address];

  always @(posedge clock) begin
    cyc       <= cyc + 1;
    prev_addr <= address;
    if (address == 20'h00003 && prev_addr != 20'h00003) cnt3 <= cnt3 + 1;
    if (we) begin
      wmem[address]    <= out;
      wtag[address]    <= epoch;
      wr_a[wr_n[5:0]]  <= address;
      wr_t[wr_n[5:0]]  <= cyc;
      wr_n             <= wr_n + 1;
    end
  end

  function automatic logic [7:0] rd(input logic [19:0] a);
    return (wtag[a] == epoch) ? wmem[a] : pmem[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic load_reset();
    epoch++;
    for (int i = 0; i < 4096; i++) pmem[i] = 8'h90;
    foreach (prog[i]) pmem[i] = prog[i];
    reset_n = 1'b0;
    tick(2);
  endtask

  task automatic run_prog(input int n);
    load_reset();
    w0 = wr_n;
    c0 = cnt3;
    reset_n = 1'b1;
    tick(n);
    ha = address;
    wn = wr_n;
    tick(20);
  endtask

  initial begin
    for (int i = 0; i < 1048576; i++) pmem[i] = 8'h90;

    // All-NOP memory: reset state, then one new fetch address every 3 cycles
    prog = '{};
    load_reset();
    check("rst_addr", 32'(address), 32'h0);
    check("rst_we", 32'(we), 32'h0);
    check("rst_out", 32'(out), 32'h0);
    w0 = wr_n;
    reset_n = 1'b1;
    pa = address;
    for (int k = 0; k < 31; k++) begin
      tick(1);
      if (address != pa) begin
        check("nop_step", 32'(address), 32'(pa) + 32'd1);
        pa = address;
      end
    end
    check("nop_addr31", 32'(address), 32'd10);
    check("nop_nowrite", 32'(wr_n - w0), 32'd0);
    #2 reset_n = 1'b0;
    #1 check("async_rst_addr", 32'(address), 32'h0);

    // MOV AL,5A ; MOV [0100],AL ; HLT
    prog = '{8'hB0, 8'h5A, 8'hA2, 8'h00, 8'h01, 8'hF4};
    run_prog(100);
    check("t2_mem100", 32'(rd(20'h00100)), 32'h5A);
    check("t2_wcount", 32'(wr_n - w0), 32'd1);
    check("t2_halt_addr", 32'(ha), 32'd5);
    check("t2_halt_hold", 32'(address), 32'(ha));
    check("t2_halt_nowr", 32'(wr_n - wn), 32'd0);
    check("t2_halt_we", 32'(we), 32'd0);

    // MOV AX,1234 ; MOV [0200],AX ; HLT
    prog = '{8'hB8, 8'h34, 8'h12, 8'hA3, 8'h00, 8'h02, 8'hF4};
    run_prog(100);
    i0 = w0[5:0];
    i1 = i0 + 6'd1;
    check("t3_mem200", 32'(rd(20'h00200)), 32'h34);
    check("t3_mem201", 32'(rd(20'h00201)), 32'h12);
    check("t3_wcount", 32'(wr_n - w0), 32'd2);
    check("t3_first_lo", 32'(wr_a[i0]), 32'h00200);
    check("t3_second_hi", 32'(wr_a[i1]), 32'h00201);
    check("t3_consec", 32'(wr_t[i1] - wr_t[i0]), 32'd1);

    // AL=FF ; ADD AL,1 (CF=1) ; JC +2 ; MOV AL,11 ; MOV [0300],AL ; HLT
    prog = '{8'hB0, 8'hFF, 8'h04, 8'h01, 8'h72, 8'h02, 8'hB0, 8'h11, 8'hA2, 8'h00, 8'h03, 8'hF4};
    run_prog(150);
    check("t4_jc_taken", 32'(rd(20'h00300)), 32'h00);
    check("t4_halt_addr", 32'(ha), 32'd11);
    prog[3] = 8'h00;
    run_prog(150);
    check("t4_jc_not_taken", 32'(rd(20'h00300)), 32'h11);

    // MOV CX,3 ; L: INC AX ; DEC CX ; JNZ L ; MOV [0400],AL ; HLT
    prog = '{8'hB9, 8'h03, 8'h00, 8'h40, 8'h49, 8'h75, 8'hFC, 8'hA2, 8'h00, 8'h04, 8'hF4};
    run_prog(200);
    check("t5_loop_al", 32'(rd(20'h00400)), 32'h03);
    check("t5_loop_fetches", 32'(cnt3 - c0), 32'd3);
    check("t5_halt_addr", 32'(ha), 32'd10);

    // MOV AX,0010 ; MOV DS,AX ; MOV AL,77 ; MOV [0000],AL ; HLT
    prog = '{8'hB8, 8'h10, 8'h00, 8'h8E, 8'hD8, 8'hB0, 8'h77, 8'hA2, 8'h00, 8'h00, 8'hF4};
    run_prog(150);
    check("t6_ds_mem100", 32'(rd(20'h00100)), 32'h77);
    check("t6_ds_mem000", 32'(rd(20'h00000)), 32'hB8);
    check("t6_wcount", 32'(wr_n - w0), 32'd1);

    // Word AND/OR/XOR/SUB, then CMP AL,1 driving JZ/JC/JP/JL
    prog = '{8'hB8, 8'h34, 8'h12, 8'h25, 8'hF0, 8'h0F, 8'h0D, 8'h01, 8'h00, 8'h35, 8'hFF, 8'hFF,
             8'hA3, 8'h00, 8'h06, 8'h2D, 8'hCE, 8'hFD, 8'h74, 8'h02, 8'hB0, 8'h11, 8'h3C, 8'h01,
             8'h72, 8'h02, 8'hB0, 8'h22, 8'h7A, 8'h02, 8'hB0, 8'h33, 8'h7C, 8'h02, 8'hB0, 8'h44,
             8'hA3, 8'h10, 8'h06, 8'hF4};
    run_prog(300);
    check("t7_logic_lo", 32'(rd(20'h00600)), 32'hCE);
    check("t7_logic_hi", 32'(rd(20'h00601)), 32'hFD);
    check("t7_flags_lo", 32'(rd(20'h00610)), 32'h00);
    check("t7_flags_hi", 32'(rd(20'h00611)), 32'h00);
    check("t7_halt_addr", 32'(ha), 32'd39);

    // MOV AX,7FFF ; INC AX (OF) ; JO ; STC ; JC ; CLC ; JNC ; MOV [0500],AX
    prog = '{8'hB8, 8'hFF, 8'h7F, 8'h40, 8'h70, 8'h02, 8'hB0, 8'h11, 8'hF9, 8'h72, 8'h02,
             8'hB0, 8'h22, 8'hF8, 8'h73, 8'h02, 8'hB0, 8'h33, 8'hA3, 8'h00, 8'h05, 8'hF4};
    run_prog(200);
    check("t8_inc_of_lo", 32'(rd(20'h00500)), 32'h00);
    check("t8_inc_of_hi", 32'(rd(20'h00501)), 32'h80);
    check("t8_halt_addr", 32'(ha), 32'd21);

    // JMP rel16 ; MOV AH,44 ; ADD AL,FF (AH untouched) ; JMP rel8 ; MOV [0700],AX
    prog = '{8'hE9, 8'h02, 8'h00, 8'hF4, 8'hF4, 8'hB4, 8'h44, 8'h04, 8'hFF, 8'hEB, 8'h01,
             8'hF4, 8'hA3, 8'h00, 8'h07, 8'hF4};
    run_prog(200);
    check("t9_jmp_lo", 32'(rd(20'h00700)), 32'hFF);
    check("t9_jmp_hi", 32'(rd(20'h00701)), 32'h44);
    check("t9_halt_addr", 32'(ha), 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
